vit_frame_ctrl: RTL and testbench
=================================

Name: vit_frame_ctrl

Overview:
Frame-level controller for the 4-state, K=3 Viterbi decoder. It sequences one frame through three phases: path-metric init, ACS/survivor-write per symbol, then traceback. It drives the path-metric register update enable and the survivor-memory write port. It also raises a normalization request when the smallest path metric nears overflow.

Parameters:
LEN_W, 10, width of frame length and symbol counter (max frame 1023 symbols)
PM_W, 8, path-metric width
NORM_THRESH, 128, normalization trigger level; min PM >= this requests subtract-by-NORM_THRESH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  begin frame; sampled in IDLE only
abort_i  in  1  abandon current frame; any state
frame_len_i  in  LEN_W  symbols in frame, including tail; latched on accepted start
sym_valid_i  in  1  received symbol pair available at BMU input
sym_ready_o  out  1  controller accepts a symbol this cycle
pm_min_i  in  PM_W  minimum of the four current path metrics
pm_init_o  out  1  one-cycle pulse; PM registers reload to S0=0, S1..S3=255
pm_en_o  out  1  PM register update enable (valid_i of PM register bank)
norm_o  out  1  ACSU subtracts NORM_THRESH from all new metrics this update
sm_wr_en_o  out  1  survivor-memory write enable
sm_wr_addr_o  out  LEN_W  survivor-memory write address
tb_start_o  out  1  one-cycle traceback start pulse
tb_len_o  out  LEN_W  frame length presented to traceback unit
tb_done_i  in  1  traceback finished
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, frame complete
err_o  out  1  one-cycle pulse, start rejected (frame_len_i == 0)

Behaviour:
- Reset, async: state=IDLE, counter=0, len_q=0. All registered outputs 0.
- States: IDLE, INIT, ACS, TB, DONE.
- IDLE: start_i && frame_len_i!=0 -> latch len_q, counter=0, go INIT. start_i && frame_len_i==0 -> err_o=1 next cycle, stay IDLE.
- INIT: exactly one cycle. pm_init_o=1 (registered, asserted while in INIT). Then go ACS.
- ACS: sym_ready_o=1. Accept = sym_valid_i && sym_ready_o. On accept, the following are asserted combinationally in the same cycle:
  - pm_en_o=1 and sm_wr_en_o=1.
  - sm_wr_addr_o=counter.
  - norm_o=(pm_min_i >= NORM_THRESH).
  - Counter increments on the accept edge.
  No accept -> pm_en_o, sm_wr_en_o and norm_o are 0; counter and PM hold. Gaps of any length are allowed.
- ACS exit: an accept with counter==len_q-1 moves to TB next cycle. Counter is not wrapped; it holds len_q.
- sym_ready_o=0 in every state except ACS. pm_en_o is never 1 outside ACS.
- TB: tb_start_o=1 for exactly the first cycle in TB. tb_len_o=len_q throughout TB and is otherwise 0. tb_done_i -> DONE; a tb_done_i coincident with tb_start_o is honoured.
- DONE: done_o=1 for one cycle, then IDLE. start_i in DONE is ignored.
- abort_i has priority over all transitions:
  - Next state is IDLE and counter clears.
  - No done_o. Any pending tb_start_o is suppressed.
  - Outputs of the abort cycle still follow the current state, so an ACS accept in the abort cycle still writes.
- busy_o is registered and equals (state!=IDLE).
- norm_o is evaluated only on accept. pm_min_i is trusted to be from the current (pre-update) PM registers.

Test Plan:
- Reset mid-ACS, counter=5 -> all outputs 0 immediately, state IDLE; next start runs INIT normally with pm_init_o pulse of 1 cycle.
- start_i, frame_len_i=4, sym_valid_i held 1:
  - pm_init_o 1 cycle.
  - 4 consecutive pm_en_o cycles, sm_wr_addr_o=0,1,2,3.
  - tb_start_o 1 cycle with tb_len_o=4.
  - tb_done_i 3 cycles later -> done_o 1 cycle, busy_o falls.
- frame_len_i=3, sym_valid_i pattern 1,0,0,1,0,1 -> pm_en_o only on the 3 valid cycles, addresses 0,1,2, PM held during gaps.
- pm_min_i=127 on first accept, 128 on second accept, 200 during a non-accept cycle -> norm_o 0 on first, 1 on second, 0 during non-accept.
- abort_i in ACS after 2 accepts, and separately on the first TB cycle -> IDLE next cycle, no done_o, no tb_start_o in the TB case; next frame addresses restart at 0.
- start_i with frame_len_i=0 -> err_o 1 cycle, busy_o stays 0; start_i during TB is ignored.

Source files
------------

// File: rtl/vit_frame_ctrl.sv
// vit_frame_ctrl: frame sequencer for the 4-state K=3 Viterbi decoder.
// A frame goes IDLE -> INIT (one-cycle PM reload) -> ACS (one accept per
// symbol, survivor write + PM update) -> TB (traceback handshake) -> DONE.
// abort_i returns to IDLE from any state. The ACS strobes are combinational
// so they follow the symbol handshake in the same cycle. The status and pulse
// outputs are registered from the next state so they line up with the state
// they describe.
module vit_frame_ctrl #(
  parameter int LEN_W       = 10,
  parameter int PM_W        = 8,
  parameter int NORM_THRESH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic             sym_valid_i,
  output logic             sym_ready_o,
  input  logic [PM_W-1:0]  pm_min_i,
  output logic             pm_init_o,
  output logic             pm_en_o,
  output logic             norm_o,
  output logic             sm_wr_en_o,
  output logic [LEN_W-1:0] sm_wr_addr_o,
  output logic             tb_start_o,
  output logic [LEN_W-1:0] tb_len_o,
  input  logic             tb_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [PM_W-1:0]  NORM_LVL = PM_W'(NORM_THRESH);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_ACS  = 3'd2,
    S_TB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_cnt_next;
  logic [LEN_W-1:0] w_len_next;
  logic             w_accept;
  logic             w_last;
  logic             w_err;

  logic             r_pm_init;
  logic             r_sym_ready;
  logic             r_tb_start;
  logic [LEN_W-1:0] r_tb_len;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  // Symbol handshake and the last-symbol detect for the ACS phase.
  always_comb begin
    w_accept = (r_state == S_ACS) && sym_valid_i;
    w_last   = (r_cnt == (r_len - LEN_ONE));
  end

  // Next-state, counter and length-latch decisions; abort overrides everything.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_len_next = r_len;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && (frame_len_i != '0)) begin
          w_next     = S_INIT;
          w_len_next = frame_len_i;
          w_cnt_next = '0;
        end else if (start_i) begin
          w_err = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_INIT: begin
        w_next = S_ACS;
      end
      S_ACS: begin
        if (w_accept) begin
          w_cnt_next = r_cnt + LEN_ONE;
          if (w_last) begin
            w_next = S_TB;
          end else begin
            w_next = S_ACS;
          end
        end else begin
          w_next = S_ACS;
        end
      end
      S_TB: begin
        if (tb_done_i) begin
          w_next = S_DONE;
        end else begin
          w_next = S_TB;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort_i) begin
      w_next     = S_IDLE;
      w_cnt_next = '0;
    end else begin
      w_cnt_next = w_cnt_next;
    end
  end

  // State, symbol counter and latched frame length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_len   <= w_len_next;
    end
  end

  // Registered status/pulse outputs that describe the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm_init   <= 1'b0;
      r_sym_ready <= 1'b0;
      r_tb_start  <= 1'b0;
      r_tb_len    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pm_init   <= (w_next == S_INIT);
      r_sym_ready <= (w_next == S_ACS);
      r_tb_start  <= (w_next == S_TB) && (r_state != S_TB);
      r_tb_len    <= (w_next == S_TB) ? w_len_next : '0;
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      r_err       <= w_err;
    end
  end

  // An abort landing on the first TB cycle withdraws the traceback start.
  always_comb begin
    sym_ready_o  = r_sym_ready;
    pm_init_o    = r_pm_init;
    pm_en_o      = w_accept;
    sm_wr_en_o   = w_accept;
    sm_wr_addr_o = r_cnt;
    norm_o       = w_accept && (pm_min_i >= NORM_LVL);
    tb_start_o   = r_tb_start && !abort_i;
    tb_len_o     = r_tb_len;
    busy_o       = r_busy;
    done_o       = r_done;
    err_o        = r_err;
  end

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// Self-checking bench for vit_frame_ctrl. Each task drives one scenario and
// compares against expectations built from the frame rules: k-th accepted
// symbol writes address k, traceback starts the cycle after the last accept,
// done follows tb_done by one cycle, and so on.
module tb_vit_frame_ctrl;
  localparam int LEN_W = 10;
  localparam int PM_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [LEN_W-1:0] frame_len_i = '0;
  logic             sym_valid_i = 1'b0;
  logic [PM_W-1:0]  pm_min_i = '0;
  logic             tb_done_i = 1'b0;
  logic             sym_ready_o, pm_init_o, pm_en_o, norm_o, sm_wr_en_o;
  logic [LEN_W-1:0] sm_wr_addr_o, tb_len_o;
  logic             tb_start_o, busy_o, done_o, err_o;

  int n_pass = 0;
  int n_total = 0;

  vit_frame_ctrl #(.LEN_W(LEN_W), .PM_W(PM_W), .NORM_THRESH(128)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .frame_len_i(frame_len_i), .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o),
    .pm_min_i(pm_min_i), .pm_init_o(pm_init_o), .pm_en_o(pm_en_o), .norm_o(norm_o),
    .sm_wr_en_o(sm_wr_en_o), .sm_wr_addr_o(sm_wr_addr_o), .tb_start_o(tb_start_o),
    .tb_len_o(tb_len_o), .tb_done_i(tb_done_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Observed flag bundle: ready, init, pm_en, norm, wr_en, tb_start, busy, done, err.
  logic [8:0] obs;
  assign obs = {sym_ready_o, pm_init_o, pm_en_o, norm_o, sm_wr_en_o,
                tb_start_o, busy_o, done_o, err_o};

  function automatic logic [8:0] ef(input logic rdy, input logic ini, input logic en,
                                    input logic nrm, input logic tbs, input logic bsy,
                                    input logic dn, input logic er);
    return {rdy, ini, en, nrm, en, tbs, bsy, dn, er};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (obs !== 9'd0 || sm_wr_addr_o !== '0 || tb_len_o !== '0)
      $display("FAIL reset_state: got flags=%b addr=%0d tblen=%0d want 0/0/0", obs, sm_wr_addr_o, tb_len_o);
    else n_pass++;
    #2 rst_n = 1'b1;
    step();
    // run a frame into ACS and accept 5 symbols, then reset asynchronously
    start_i = 1'b1; frame_len_i = 10'd8;
    step();
    start_i = 1'b0;
    step();
    sym_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0) || sm_wr_addr_o !== 10'd5)
      $display("FAIL reset_pre: got flags=%b addr=%0d want ACS accept at addr 5", obs, sm_wr_addr_o);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (obs !== 9'd0 || sm_wr_addr_o !== '0 || tb_len_o !== '0)
      $display("FAIL reset_mid_acs: got flags=%b addr=%0d tblen=%0d want 0/0/0", obs, sm_wr_addr_o, tb_len_o);
    else n_pass++;
    sym_valid_i = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_frame(input int len, input int pct, input int tbd);
    int acc;
    int guard;
    logic v;
    logic nrm;
    start_i = 1'b1; frame_len_i = len[LEN_W-1:0];
    @(negedge clk);
    n_total++;
    if (obs !== 9'd0) $display("FAIL frame_idle: got %b want %b", obs, 9'd0);
    else n_pass++;
    step();
    start_i = 1'b0; frame_len_i = LEN_W'($urandom_range(1023));
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0))
      $display("FAIL frame_init: got %b want init pulse", obs);
    else n_pass++;
    step();
    acc = 0; guard = 0;
    while (acc < len && guard < len * 40 + 40) begin
      v = ($urandom_range(99) < pct);
      sym_valid_i = v;
      pm_min_i = PM_W'($urandom_range(255));
      nrm = v && (pm_min_i >= 8'd128);
      @(negedge clk);
      n_total++;
      if (obs !== ef(1'b1, 1'b0, v, nrm, 1'b0, 1'b1, 1'b0, 1'b0))
        $display("FAIL frame_acs: got %b want %b (pm_min=%0d)", obs,
                 ef(1'b1, 1'b0, v, nrm, 1'b0, 1'b1, 1'b0, 1'b0), pm_min_i);
      else n_pass++;
      if (v) begin
        n_total++;
        if (sm_wr_addr_o !== acc[LEN_W-1:0])
          $display("FAIL frame_addr: got %0d want %0d", sm_wr_addr_o, acc);
        else n_pass++;
      end
      step();
      if (v) acc++;
      guard++;
    end
    sym_valid_i = 1'b0;
    if (acc < len) begin
      n_total++;
      $display("FAIL frame_budget: got %0d accepts want %0d", acc, len);
    end
    for (int k = 0; k <= tbd; k++) begin
      tb_done_i = (k == tbd);
      start_i = $urandom_range(1);
      @(negedge clk);
      n_total++;
      if (obs !== ef(1'b0, 1'b0, 1'b0, 1'b0, (k == 0), 1'b1, 1'b0, 1'b0) || tb_len_o !== len[LEN_W-1:0])
        $display("FAIL frame_tb: got flags=%b tblen=%0d want tb_start=%0d tblen=%0d", obs, tb_len_o, (k == 0), len);
      else n_pass++;
      step();
    end
    tb_done_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0))
      $display("FAIL frame_done: got %b want done pulse", obs);
    else n_pass++;
    step();
    start_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs !== 9'd0 || tb_len_o !== '0)
      $display("FAIL frame_end_idle: got flags=%b tblen=%0d want 0", obs, tb_len_o);
    else n_pass++;
    step();
  endtask

  task automatic test_norm_gaps();
    logic            pv [6];
    logic [PM_W-1:0] pm [6];
    logic            pn [6];
    int acc;
    pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pm = '{8'd127, 8'd200, 8'd200, 8'd128, 8'd200, 8'd50};
    pn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    start_i = 1'b1; frame_len_i = 10'd3;
    step();
    start_i = 1'b0;
    step();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      sym_valid_i = pv[i];
      pm_min_i = pm[i];
      @(negedge clk);
      n_total++;
      if (obs !== ef(1'b1, 1'b0, pv[i], pn[i], 1'b0, 1'b1, 1'b0, 1'b0))
        $display("FAIL norm_gap_%0d: got %b want %b", i, obs, ef(1'b1, 1'b0, pv[i], pn[i], 1'b0, 1'b1, 1'b0, 1'b0));
      else n_pass++;
      if (pv[i]) begin
        n_total++;
        if (sm_wr_addr_o !== acc[LEN_W-1:0])
          $display("FAIL norm_addr_%0d: got %0d want %0d", i, sm_wr_addr_o, acc);
        else n_pass++;
        acc++;
      end
      step();
    end
    sym_valid_i = 1'b0;
    tb_done_i = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0) || tb_len_o !== 10'd3)
      $display("FAIL norm_tb: got flags=%b tblen=%0d want tb_start tblen=3", obs, tb_len_o);
    else n_pass++;
    step();
    tb_done_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0))
      $display("FAIL norm_done: got %b want done pulse", obs);
    else n_pass++;
    step();
  endtask

  task automatic test_abort_acs();
    pm_min_i = 8'd0;
    start_i = 1'b1; frame_len_i = 10'd6;
    step();
    start_i = 1'b0;
    step();
    sym_valid_i = 1'b1;
    step();
    step();
    abort_i = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0) || sm_wr_addr_o !== 10'd2)
      $display("FAIL abort_acs_cycle: got flags=%b addr=%0d want write at addr 2", obs, sm_wr_addr_o);
    else n_pass++;
    step();
    abort_i = 1'b0;
    sym_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (obs !== 9'd0) $display("FAIL abort_acs_idle_%0d: got %b want 0", i, obs);
      else n_pass++;
      step();
    end
    test_frame(3, 100, 2);
  endtask

  task automatic test_abort_tb();
    start_i = 1'b1; frame_len_i = 10'd1;
    step();
    start_i = 1'b0;
    step();
    sym_valid_i = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0) || sm_wr_addr_o !== 10'd0)
      $display("FAIL abort_tb_accept: got flags=%b addr=%0d want write at addr 0", obs, sm_wr_addr_o);
    else n_pass++;
    step();
    sym_valid_i = 1'b0;
    abort_i = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0) || tb_len_o !== 10'd1)
      $display("FAIL abort_tb_cycle: got flags=%b tblen=%0d want busy only, tblen=1", obs, tb_len_o);
    else n_pass++;
    step();
    abort_i = 1'b0;
    tb_done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (obs !== 9'd0 || tb_len_o !== '0)
        $display("FAIL abort_tb_idle_%0d: got flags=%b tblen=%0d want 0", i, obs, tb_len_o);
      else n_pass++;
      step();
    end
    tb_done_i = 1'b0;
  endtask

  task automatic test_err();
    start_i = 1'b1; frame_len_i = 10'd0;
    @(negedge clk);
    n_total++;
    if (obs !== 9'd0) $display("FAIL err_start: got %b want 0", obs);
    else n_pass++;
    step();
    start_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs !== ef(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1))
      $display("FAIL err_pulse: got %b want err only", obs);
    else n_pass++;
    step();
    @(negedge clk);
    n_total++;
    if (obs !== 9'd0) $display("FAIL err_clear: got %b want 0", obs);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++)
      test_frame($urandom_range(12, 1), $urandom_range(100, 30), $urandom_range(3));
  endtask

  initial begin
    test_reset();
    test_frame(4, 100, 3);
    test_norm_gaps();
    test_abort_acs();
    test_abort_tb();
    test_err();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
